// File: rtl/fetch_align_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_align_buffer_pkg
// Description : Shared constants and helpers for the fetch align buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_align_buffer_pkg;

   localparam int          HW_WIDTH  = 16;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Decode_Take encodings; 2'd3 is treated as TAKE_TWO
   localparam logic [1:0]  TAKE_NONE = 2'd0;
   localparam logic [1:0]  TAKE_ONE  = 2'd1;
   localparam logic [1:0]  TAKE_TWO  = 2'd2;

   function automatic logic is_rvc(input logic [HW_WIDTH-1:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf_slot.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf_slot
// Description : Extracts one whole instruction starting at a halfword index.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf_slot
   import fetch_align_buffer_pkg::*;
#(
   parameter int HW_DEPTH = 16,
   parameter int PTR_W    = $clog2(HW_DEPTH)
) (
   input  logic [HW_WIDTH-1:0] hwArray [HW_DEPTH],
   input  logic [PTR_W-1:0]    startIdx,
   input  logic [PTR_W:0]      avail,
   output logic [1:0]          len,
   output logic                valid,
   output logic [31:0]         instr,
   output logic                flag
);

   logic [HW_WIDTH-1:0] w_lo;
   logic [HW_WIDTH-1:0] w_hi;
   logic [PTR_W-1:0]    w_nextIdx;
   logic                w_rvc;

   // Index arithmetic wraps naturally, so an upper halfword at index 0 pairs with HW_DEPTH-1
   assign w_nextIdx = startIdx + PTR_W'(1);
   assign w_lo      = hwArray[startIdx];
   assign w_hi      = hwArray[w_nextIdx];
   assign w_rvc     = is_rvc(w_lo);

   assign len   = w_rvc ? 2'd1 : 2'd2;
   assign valid = (avail >= (PTR_W+1)'(len));
   assign flag  = valid & w_rvc;
   assign instr = !valid ? NOP_INSTR :
                  w_rvc  ? {16'h0000, w_lo} : {w_hi, w_lo};

endmodule
`default_nettype wire

// File: rtl/fetch_align_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_align_buffer
// Description : Halfword queue realigning 64-bit fetch packets into up to two
//               whole 16/32-bit instructions per cycle for the decoder.
//               Optional macro FETCHBUF_BYPASS_EN: 0-cycle bypass when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_align_buffer
   import fetch_align_buffer_pkg::*;
#(
   parameter int HW_DEPTH   = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Flush,
   input  logic                  Fetch_Valid,
   output logic                  Fetch_Ready,
   input  logic [ADDR_WIDTH-1:0] Fetch_PC,
   input  logic [63:0]           Fetch_Packet,
   output logic                  Buf_Valid_0,
   output logic                  Buf_Valid_1,
   output logic [31:0]           Buf_Instr_0,
   output logic [31:0]           Buf_Instr_1,
   output logic [ADDR_WIDTH-1:0] Buf_PC_0,
   output logic [ADDR_WIDTH-1:0] Buf_PC_1,
   output logic                  Buf_16BitFlag_0,
   output logic                  Buf_16BitFlag_1,
   input  logic [1:0]            Decode_Take
);

   localparam int PTR_W = $clog2(HW_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [HW_WIDTH-1:0]   r_mem   [HW_DEPTH];
   logic [HW_WIDTH-1:0]   w_view  [HW_DEPTH];
   logic [HW_WIDTH-1:0]   w_pktHw [4];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;
   logic [ADDR_WIDTH-1:0] r_headPc;

   logic [1:0]            w_off;
   logic                  w_write;
   logic                  w_bypass;
   logic [CNT_W-1:0]      w_written;
   logic [CNT_W-1:0]      w_removed;
   logic [CNT_W-1:0]      w_avail0;
   logic [CNT_W-1:0]      w_avail1;
   logic [1:0]            w_len0;
   logic [1:0]            w_len1;
   logic                  w_valid0;
   logic                  w_valid1;
   logic [PTR_W-1:0]      w_start1;
   logic [ADDR_WIDTH-1:0] w_basePc;
   logic [ADDR_WIDTH-1:0] w_headPcBase;

   generate
      for (genvar k = 0; k < 4; k++) begin : g_pktHw
         assign w_pktHw[k] = Fetch_Packet[k*HW_WIDTH +: HW_WIDTH];
      end
   endgenerate

   assign w_off       = Fetch_PC[2:1];
   assign Fetch_Ready = ~rst & ~Flush & (r_count <= CNT_W'(HW_DEPTH-4));
   assign w_write     = Fetch_Valid & Fetch_Ready;
   assign w_written   = w_write ? CNT_W'(3'd4 - {1'b0, w_off}) : '0;

`ifdef FETCHBUF_BYPASS_EN
   assign w_bypass = w_write & (r_count == '0);
`else
   assign w_bypass = 1'b0;
`endif

   // When bypassing, head==tail, so overlaying the incoming halfwords at tail
   // lets the slot logic see them exactly as if they were already stored.
   always_comb begin
      w_view = r_mem;
      if (w_bypass) begin
         for (int k = 0; k < 4; k++) begin
            if (CNT_W'(k) < w_written) begin
               w_view[r_tail + PTR_W'(k)] = w_pktHw[w_off + 2'(k)];
            end
         end
      end
   end

   assign w_avail0 = w_bypass ? w_written : r_count;
   assign w_basePc = w_bypass ? Fetch_PC : r_headPc;

   fetch_buf_slot #(.HW_DEPTH(HW_DEPTH), .PTR_W(PTR_W)) u_slot0 (
      .hwArray  (w_view),
      .startIdx (r_head),
      .avail    (w_avail0),
      .len      (w_len0),
      .valid    (w_valid0),
      .instr    (Buf_Instr_0),
      .flag     (Buf_16BitFlag_0)
   );

   assign w_start1 = r_head + PTR_W'(w_len0);
   assign w_avail1 = w_valid0 ? (w_avail0 - CNT_W'(w_len0)) : '0;

   fetch_buf_slot #(.HW_DEPTH(HW_DEPTH), .PTR_W(PTR_W)) u_slot1 (
      .hwArray  (w_view),
      .startIdx (w_start1),
      .avail    (w_avail1),
      .len      (w_len1),
      .valid    (w_valid1),
      .instr    (Buf_Instr_1),
      .flag     (Buf_16BitFlag_1)
   );

   assign Buf_Valid_0 = w_valid0;
   assign Buf_Valid_1 = w_valid1;
   assign Buf_PC_0    = w_valid0 ? w_basePc : '0;
   assign Buf_PC_1    = w_valid1 ? (w_basePc + ADDR_WIDTH'({w_len0, 1'b0})) : '0;

   // Over-requested takes saturate to whatever slots are actually valid
   always_comb begin
      w_removed = '0;
      if ((Decode_Take != TAKE_NONE) && w_valid0) begin
         w_removed = CNT_W'(w_len0);
      end
      if ((Decode_Take >= TAKE_TWO) && w_valid1) begin
         w_removed = w_removed + CNT_W'(w_len1);
      end
   end

   assign w_headPcBase = ((r_count == '0) && w_write) ? Fetch_PC : r_headPc;

   always_ff @(posedge clk) begin
      if (rst || Flush) begin
         r_count  <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_headPc <= '0;
      end else begin
         r_count  <= r_count + w_written - w_removed;
         r_head   <= r_head + w_removed[PTR_W-1:0];
         r_tail   <= r_tail + w_written[PTR_W-1:0];
         r_headPc <= w_headPcBase + ADDR_WIDTH'({w_removed, 1'b0});
      end
   end

   always_ff @(posedge clk) begin
      if (w_write) begin
         for (int k = 0; k < 4; k++) begin
            if (CNT_W'(k) < w_written) begin
               r_mem[r_tail + PTR_W'(k)] <= w_pktHw[w_off + 2'(k)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !Flush) begin
         assert (Decode_Take <= ({1'b0, w_valid0} + {1'b0, w_valid1}))
            else $error("Decode_Take=%0d exceeds valid slot count", Decode_Take);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_align_buffer
// Description : Directed plus randomized bench against a halfword-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_align_buffer;

   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, Flush, Fetch_Valid, Fetch_Ready;
   logic [31:0] Fetch_PC;
   logic [63:0] Fetch_Packet;
   logic        Buf_Valid_0, Buf_Valid_1;
   logic [31:0] Buf_Instr_0, Buf_Instr_1;
   logic [31:0] Buf_PC_0, Buf_PC_1;
   logic        Buf_16BitFlag_0, Buf_16BitFlag_1;
   logic [1:0]  Decode_Take;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queue of buffered halfwords plus PC of the oldest one
   bit [15:0]   mq[$];
   logic [31:0] mpc = '0;

   bit          ev0, ev1, ef0, ef1;
   int          el0, el1, nValid;
   logic [31:0] ei0, ei1, ep0, ep1;

   fetch_align_buffer #(.HW_DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .Flush           (Flush),
      .Fetch_Valid     (Fetch_Valid),
      .Fetch_Ready     (Fetch_Ready),
      .Fetch_PC        (Fetch_PC),
      .Fetch_Packet    (Fetch_Packet),
      .Buf_Valid_0     (Buf_Valid_0),
      .Buf_Valid_1     (Buf_Valid_1),
      .Buf_Instr_0     (Buf_Instr_0),
      .Buf_Instr_1     (Buf_Instr_1),
      .Buf_PC_0        (Buf_PC_0),
      .Buf_PC_1        (Buf_PC_1),
      .Buf_16BitFlag_0 (Buf_16BitFlag_0),
      .Buf_16BitFlag_1 (Buf_16BitFlag_1),
      .Decode_Take     (Decode_Take)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic calc();
      int n;
      n   = mq.size();
      ev0 = 0; ev1 = 0; ef0 = 0; ef1 = 0; el0 = 0; el1 = 0;
      ei0 = NOP; ei1 = NOP; ep0 = '0; ep1 = '0;
      if (n >= 1) begin
         el0 = (mq[0][1:0] == 2'b11) ? 2 : 1;
         if (n >= el0) begin
            ev0 = 1;
            ep0 = mpc;
            ef0 = (el0 == 1);
            ei0 = (el0 == 1) ? {16'h0000, mq[0]} : {mq[1], mq[0]};
            if (n >= el0 + 1) begin
               el1 = (mq[el0][1:0] == 2'b11) ? 2 : 1;
               if (n >= el0 + el1) begin
                  ev1 = 1;
                  ep1 = mpc + 32'(2 * el0);
                  ef1 = (el1 == 1);
                  ei1 = (el1 == 1) ? {16'h0000, mq[el0]} : {mq[el0+1], mq[el0]};
               end
            end
         end
      end
      nValid = int'(ev0) + int'(ev1);
   endtask

   task automatic step(input bit r, input bit f, input bit fv, input logic [31:0] pc,
                       input logic [63:0] pkt, input logic [1:0] tk);
      bit acc, wasEmpty;
      int rem, off;
      rst = r; Flush = f; Fetch_Valid = fv; Fetch_PC = pc; Fetch_Packet = pkt; Decode_Take = tk;
      #1;
      calc();
      chk("ready",  Fetch_Ready, 64'(!r && !f && (mq.size() <= DEPTH - 4)));
      chk("valid0", Buf_Valid_0, 64'(ev0));
      chk("instr0", Buf_Instr_0, 64'(ei0));
      chk("pc0",    Buf_PC_0,    64'(ep0));
      chk("flag0",  Buf_16BitFlag_0, 64'(ef0));
      chk("valid1", Buf_Valid_1, 64'(ev1));
      chk("instr1", Buf_Instr_1, 64'(ei1));
      chk("pc1",    Buf_PC_1,    64'(ep1));
      chk("flag1",  Buf_16BitFlag_1, 64'(ef1));
      acc = fv && !r && !f && (mq.size() <= DEPTH - 4);
      @(posedge clk);
      if (r || f) begin
         mq.delete();
         mpc = '0;
      end else begin
         wasEmpty = (mq.size() == 0);
         rem = 0;
         if (tk >= 2'd1 && ev0) rem += el0;
         if (tk >= 2'd2 && ev1) rem += el1;
         repeat (rem) void'(mq.pop_front());
         mpc = mpc + 32'(2 * rem);
         if (acc) begin
            if (wasEmpty) mpc = pc;
            off = int'(pc[2:1]);
            for (int k = off; k < 4; k++) mq.push_back(pkt[16*k +: 16]);
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [63:0] rpkt();
      logic [63:0] p;
      logic [15:0] h;
      p = '0;
      for (int k = 0; k < 4; k++) begin
         h = 16'($urandom);
         if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
         p[16*k +: 16] = h;
      end
      return p;
   endfunction

   // Next fetch PC: contiguous with buffered data, or anywhere when empty
   function automatic logic [31:0] tailPc();
      if (mq.size() == 0)
         return {21'd0, 8'($urandom_range(0, 255)), 3'b000} + 32'(2 * $urandom_range(0, 3));
      return mpc + 32'(2 * mq.size());
   endfunction

   task automatic rstep(input int flushPct);
      logic [1:0] tk;
      bit f, fv;
      calc();
      tk = 2'($urandom_range(0, nValid));
      f  = ($urandom_range(0, 99) < flushPct);
      fv = ($urandom_range(0, 3) != 0);
      step(1'b0, f, fv, tailPc(), rpkt(), tk);
   endtask

   initial begin
      rst = 1'b1; Flush = 1'b0; Fetch_Valid = 1'b0; Fetch_PC = '0;
      Fetch_Packet = '0; Decode_Take = 2'd0;
      @(negedge clk);

      // Reset
      step(1, 0, 0, 32'h0, 64'h0, 2'd0);
      chk("rst_valid0", Buf_Valid_0, 64'(0));
      chk("rst_instr0", Buf_Instr_0, 64'(NOP));

      // Two 32-bit words
      step(0, 0, 1, 32'h0, 64'h00000013_00000013, 2'd0);
      chk("t1_v0", Buf_Valid_0, 64'(1));
      chk("t1_v1", Buf_Valid_1, 64'(1));
      chk("t1_pc1", Buf_PC_1, 64'h4);
      chk("t1_f0", Buf_16BitFlag_0, 64'(0));
      step(0, 1, 0, 32'h0, 64'h0, 2'd0);

      // Two compressed then one 32-bit
      step(0, 0, 1, 32'h0, 64'h0000_0013_57C1_57C1, 2'd0);
      chk("t2_i0", Buf_Instr_0, 64'h57C1);
      chk("t2_pc1", Buf_PC_1, 64'h2);
      chk("t2_f1", Buf_16BitFlag_1, 64'(1));
      step(0, 0, 0, 32'h0, 64'h0, 2'd2);
      chk("t2_next_i0", Buf_Instr_0, 64'h13);
      chk("t2_next_pc0", Buf_PC_0, 64'h4);
      chk("t2_next_f0", Buf_16BitFlag_0, 64'(0));
      step(0, 1, 0, 32'h0, 64'h0, 2'd0);

      // 32-bit instruction split across packets
      step(0, 0, 1, 32'h6, 64'h0013_0000_0000_0000, 2'd0);
      chk("split_v0_a", Buf_Valid_0, 64'(0));
      step(0, 0, 0, 32'h0, 64'h0, 2'd0);
      chk("split_v0_b", Buf_Valid_0, 64'(0));
      step(0, 0, 1, 32'h8, 64'h0001_0001_0001_0000, 2'd0);
      chk("split_i0", Buf_Instr_0, 64'h13);
      chk("split_pc0", Buf_PC_0, 64'h6);
      step(0, 1, 0, 32'h0, 64'h0, 2'd0);

      // Fill to HW_DEPTH-3, then drain by one slot per cycle through the wrap
      step(0, 0, 1, 32'h206, 64'h1233_0000_0000_0000, 2'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, tailPc(), rpkt(), 2'd0);
      chk("fill_ready0", Fetch_Ready, 64'(0));
      step(0, 0, 1, tailPc(), rpkt(), 2'd1);
      chk("fill_ready1", Fetch_Ready, 64'(1));
      for (int i = 0; i < 60; i++) begin
         calc();
         step(0, 0, 1, tailPc(), rpkt(), ev0 ? 2'd1 : 2'd0);
      end

      // Flush beats a same-cycle write and take
      step(0, 1, 1, tailPc(), rpkt(), 2'd2);
      chk("flush_v0", Buf_Valid_0, 64'(0));
      step(0, 0, 1, 32'h104, 64'h1111_4505_2222_3333, 2'd0);
      chk("redir_pc0", Buf_PC_0, 64'h104);
      chk("redir_i0", Buf_Instr_0, 64'h4505);
      chk("redir_i1", Buf_Instr_1, 64'h1111);
      chk("redir_pc1", Buf_PC_1, 64'h106);

      // Random traffic
      for (int i = 0; i < 400; i++) rstep(3);

      // Reset mid-stream
      for (int i = 0; i < 6; i++) rstep(0);
      step(1, 0, 1, tailPc(), rpkt(), 2'd0);
      chk("mrst_ready", Fetch_Ready, 64'(0));
      chk("mrst_v0", Buf_Valid_0, 64'(0));
      chk("mrst_i0", Buf_Instr_0, 64'(NOP));
      chk("mrst_pc0", Buf_PC_0, 64'h0);
      chk("mrst_v1", Buf_Valid_1, 64'(0));
      step(0, 0, 0, 32'h0, 64'h0, 2'd0);
      for (int i = 0; i < 20; i++) rstep(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
